po_input_loader: RTL and testbench

Hardware writer for the PO core's input-array storage. It accepts a stream of 64-bit cone-data words, writes each word at the same address into the main input array and all six replicated RAM banks in one cycle, then issues a one-cycle `go_i` pulse to the core. It waits for the core's `done` and reports completion. It takes over the image load that simulation does by backdoor, so the core can run on silicon from a host or DMA stream.

---
 rtl/po_input_loader.sv | 173 +++++++++++++++++
 tb/tb_po_input_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/po_input_loader.sv
// po_input_loader
//   Streams 64-bit cone-data words into the PO core's input array. Each
//   accepted beat is written at the same address into the main input array
//   and all replicated banks in a single cycle. When the image is loaded the
//   block waits out one flush cycle, pulses go_o to start the core, then waits
//   for the core's done and reports completion.
//
// Optional feature (macro PO_LOADER_CHECKSUM_EN):
//   adds checksum_o, the modulo-2^DATA_W sum of every word accepted in the
//   current load. It clears on an accepted start and on reset.
//
// Ports
//   clk, reset     single clock, synchronous active-high reset
//   start_i        begin a load (sampled only when idle)
//   word_count_i   words in this load, 1..2^ADDR_W, latched with start_i
//   s_data_i/s_valid_i/s_ready_o   input word stream (valid/ready)
//   wr_addr_o/wr_data_o/bank_we_o  RAM write port; all bank lanes fire together
//   go_o           one-cycle start pulse to the core
//   core_done_i    core completion, honoured only while waiting for it
//   busy_o         high whenever not idle
//   load_done_o    one-cycle pulse when the core run has completed
//   err_o          one-cycle pulse when a start with a bad count is rejected
//   checksum_o     (macro only) running sum of accepted words
module po_input_loader #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 9,
   parameter int NUM_BANKS = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic [ADDR_W:0]      word_count_i,
   input  logic [DATA_W-1:0]    s_data_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   output logic [ADDR_W-1:0]    wr_addr_o,
   output logic [DATA_W-1:0]    wr_data_o,
   output logic [NUM_BANKS-1:0] bank_we_o,
   output logic                 go_o,
   input  logic                 core_done_i,
   output logic                 busy_o,
   output logic                 load_done_o,
`ifdef PO_LOADER_CHECKSUM_EN
   output logic                 err_o,
   output logic [DATA_W-1:0]    checksum_o
`else
   output logic                 err_o
`endif
);

   // Array capacity; needs ADDR_W+1 bits so a full-array load is representable.
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_GO,
      S_WAIT_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [ADDR_W:0] cnt_q;     // next address to write == beats accepted so far
   logic [ADDR_W:0] count_q;   // words in this load
   logic            count_ok;
   logic            start_ok;
   logic            start_bad;
   logic            all_taken;
   logic            accept;

   assign count_ok  = (word_count_i != '0) && (word_count_i <= DEPTH);
   assign start_ok  = (state_q == S_IDLE) && start_i && count_ok;
   assign start_bad = (state_q == S_IDLE) && start_i && !count_ok;

   // Once every beat has been taken, ready drops while the state is still
   // LOAD; that LOAD cycle is the one in which the final word is on the
   // write port. cnt_q stops at count_q, so a full-array load never wraps
   // back to address 0.
   assign all_taken = (cnt_q == count_q);
   assign s_ready_o = (state_q == S_LOAD) && !all_taken;
   assign accept    = s_ready_o && s_valid_i;

   assign go_o      = (state_q == S_GO);
   assign busy_o    = (state_q != S_IDLE);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   //   LOAD   -> FLUSH once the last word is being written
   //   FLUSH  : a quiet cycle so the core never starts in the same cycle a
   //            bank is written
   //   GO     : single go_o cycle
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (start_ok)    state_d = S_LOAD;
         S_LOAD:      if (all_taken)   state_d = S_FLUSH;
         S_FLUSH:                      state_d = S_GO;
         S_GO:                         state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (core_done_i) state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Count latch and address counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         count_q <= '0;
      end else if (start_ok) begin
         cnt_q   <= '0;
         count_q <= word_count_i;
      end else if (accept) begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // RAM write port: one registered stage after the handshake. Reset clears
   // the enables, so a write queued on the reset edge never happens.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr_o <= '0;
         wr_data_o <= '0;
         bank_we_o <= '0;
      end else begin
         bank_we_o <= {NUM_BANKS{accept}};
         if (accept) begin
            wr_addr_o <= cnt_q[ADDR_W-1:0];
            wr_data_o <= s_data_i;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Status pulses
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         err_o       <= 1'b0;
         load_done_o <= 1'b0;
      end else begin
         err_o       <= start_bad;
         load_done_o <= (state_q == S_WAIT_DONE) && core_done_i;
      end
   end

`ifdef PO_LOADER_CHECKSUM_EN
   // Running sum of accepted words; it is frozen from the last beat until
   // the next accepted start, so it is stable by the go_o cycle.
   logic [DATA_W-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (reset)         sum_q <= '0;
      else if (start_ok) sum_q <= '0;
      else if (accept)   sum_q <= sum_q + s_data_i;
   end

   assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_po_input_loader.sv
// tb_po_input_loader
//   Directed stimulus for po_input_loader. A transaction-level model tracks
//   what the loader must be doing (busy, beats taken, when go is due, which
//   writes are pending) and one compare step checks every DUT output against
//   it each cycle. Literal expectations per scenario pin the model itself.
module tb_po_input_loader;
   localparam int DATA_W    = 64;
   localparam int ADDR_W    = 9;
   localparam int NUM_BANKS = 7;
   localparam int DEPTH     = 1 << ADDR_W;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start_i;
   logic [ADDR_W:0]      word_count_i;
   logic [DATA_W-1:0]    s_data_i;
   logic                 s_valid_i;
   logic                 s_ready_o;
   logic [ADDR_W-1:0]    wr_addr_o;
   logic [DATA_W-1:0]    wr_data_o;
   logic [NUM_BANKS-1:0] bank_we_o;
   logic                 go_o;
   logic                 core_done_i;
   logic                 busy_o;
   logic                 load_done_o;
   logic                 err_o;
`ifdef PO_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0]    checksum_o;
`endif

   always #5 clk = ~clk;

   po_input_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .word_count_i(word_count_i),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .bank_we_o   (bank_we_o),
      .go_o        (go_o),
      .core_done_i (core_done_i),
      .busy_o      (busy_o),
      .load_done_o (load_done_o),
      .err_o       (err_o)
`ifdef PO_LOADER_CHECKSUM_EN
      , .checksum_o(checksum_o)
`endif
   );

   // ------------------------------------------------------------------
   // Model state
   // ------------------------------------------------------------------
   typedef struct {
      int          addr;
      logic [63:0] data;
      int          due;     // cycle in which the write must be on the port
   } wr_t;

   wr_t         wq[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   bit          m_busy = 0;
   bit          m_wait = 0;   // go has been issued, waiting for core done
   int          m_n = 0;
   int          m_acc = 0;
   int          m_go_at = -1;
   logic [63:0] m_sum = '0;
   bit          e_err = 0;
   bit          e_done = 0;
   bit          cur_ready = 0;

   // Observations of DUT activity, for the literal per-scenario checks
   int obs_we = 0, obs_go = 0, obs_err = 0, obs_done = 0;
   int obs_last_addr = -1, obs_go_cyc = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
   endtask

   task automatic compare();
      bit e_go, e_we;
      logic [NUM_BANKS-1:0] we_all;
      we_all    = '1;
      cur_ready = m_busy && !m_wait && (m_acc < m_n);
      e_go      = (cyc == m_go_at);
      e_we      = (wq.size() > 0) && (wq[0].due == cyc);
      chk("s_ready", s_ready_o, cur_ready);
      chk("go", go_o, e_go);
      chk("busy", busy_o, m_busy);
      chk("err", err_o, e_err);
      chk("load_done", load_done_o, e_done);
      chk("bank_we", bank_we_o, e_we ? we_all : '0);
      if (e_we) begin
         chk("wr_addr", wr_addr_o, wq[0].addr);
         chk("wr_data", wr_data_o, wq[0].data);
         void'(wq.pop_front());
      end
`ifdef PO_LOADER_CHECKSUM_EN
      chk("checksum", checksum_o, m_sum);
`endif
      if (bank_we_o != '0) begin obs_we++; obs_last_addr = int'(wr_addr_o); end
      if (go_o)        begin obs_go++; obs_go_cyc = cyc; end
      if (err_o)       obs_err++;
      if (load_done_o) obs_done++;
   endtask

   // Advance the model across the coming clock edge using the inputs now
   // being presented.
   task automatic update();
      bit n_err, n_done;
      wr_t w;
      n_err  = 0;
      n_done = 0;
      if (reset) begin
         m_busy = 0; m_wait = 0; m_go_at = -1; m_n = 0; m_acc = 0; m_sum = '0;
         wq.delete();
      end else if (!m_busy) begin
         if (start_i) begin
            if (word_count_i == 0 || int'(word_count_i) > DEPTH) n_err = 1;
            else begin m_busy = 1; m_n = int'(word_count_i); m_acc = 0; m_sum = '0; end
         end
      end else if (m_wait) begin
         if (core_done_i) begin n_done = 1; m_busy = 0; m_wait = 0; end
      end else begin
         if (cur_ready && s_valid_i) begin
            w.addr = m_acc; w.data = s_data_i; w.due = cyc + 1;
            wq.push_back(w);
            m_acc++;
            m_sum = m_sum + s_data_i;
            if (m_acc == m_n) m_go_at = cyc + 3;   // write, flush, go
         end
         if (cyc == m_go_at) begin m_wait = 1; m_go_at = -1; end
      end
      e_err  = n_err;
      e_done = n_done;
      cyc++;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked
   // on the falling edge.
   task automatic tick();
      @(negedge clk);
      compare();
      update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_start(input int n);
      start_i = 1'b1;
      word_count_i = n[ADDR_W:0];
      tick();
      start_i = 1'b0;
   endtask

   task automatic send(input logic [63:0] d, output int t_acc);
      bit acc;
      int guard;
      guard = 0;
      t_acc = -1;
      s_valid_i = 1'b1;
      s_data_i  = d;
      do begin
         acc   = s_ready_o;
         t_acc = cyc;
         tick();
         guard++;
      end while (!acc && guard < 50);
      if (!acc) begin
         n_chk++;
         $display("FAIL send_timeout cyc=%0d got=no_ready want=ready", cyc);
      end
      s_valid_i = 1'b0;
   endtask

   task automatic wait_go();
      int g0, k;
      g0 = obs_go;
      k  = 0;
      while (obs_go == g0 && k < 20) begin tick(); k++; end
      if (obs_go == g0) begin
         n_chk++;
         $display("FAIL wait_go cyc=%0d got=no_go want=go_o", cyc);
      end
   endtask

   task automatic done_pulse();
      core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t_last, t, w0, g0, e0, d0;
      reset = 1'b1; start_i = 1'b0; word_count_i = '0; s_data_i = '0;
      s_valid_i = 1'b0; core_done_i = 1'b0;
      @(posedge clk); #1;
      tick(); tick();
      // reset state
      chk("rst_s_ready", s_ready_o, 0);
      chk("rst_wr_addr", wr_addr_o, 0);
      chk("rst_wr_data", wr_data_o, 0);
      chk("rst_bank_we", bank_we_o, 0);
      chk("rst_go", go_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done_err", {load_done_o, err_o}, 0);
      reset = 1'b0;
      tick();

      // 1: four words back to back
      w0 = obs_we; g0 = obs_go; d0 = obs_done;
      do_start(4);
      send(64'h11, t); send(64'h22, t); send(64'h33, t); send(64'h44, t_last);
      wait_go();
      chk("t1_go_latency", obs_go_cyc - t_last, 3);
      chk("t1_writes", obs_we - w0, 4);
      chk("t1_last_addr", obs_last_addr, 3);
`ifdef PO_LOADER_CHECKSUM_EN
      chk("t1_checksum", checksum_o, 64'hAA);
`endif
      idle(2);
      done_pulse();
      chk("t1_done", obs_done - d0, 1);
      chk("t1_go_count", obs_go - g0, 1);

      // 2: gap of 5 cycles after the first beat
      w0 = obs_we; g0 = obs_go;
      do_start(3);
      send(64'hDEAD_0001, t);
      idle(5);
      send(64'hDEAD_0002, t); send(64'hDEAD_0003, t);
      wait_go();
      idle(2);
      chk("t2_writes", obs_we - w0, 3);
      chk("t2_last_addr", obs_last_addr, 2);
      chk("t2_go_count", obs_go - g0, 1);
      done_pulse();

      // 3: rejected counts
      w0 = obs_we; e0 = obs_err;
      do_start(0); tick();
      do_start(513); tick();
      chk("t3_err_count", obs_err - e0, 2);
      chk("t3_writes", obs_we - w0, 0);
      chk("t3_busy", busy_o, 0);

      // 4: full array
      w0 = obs_we;
      do_start(512);
      for (int i = 0; i < 512; i++) send(64'hC0DE_0000_0000_0000 | 64'(i), t);
      wait_go();
      idle(4);
      chk("t4_writes", obs_we - w0, 512);
      chk("t4_last_addr", obs_last_addr, 511);
      done_pulse();

      // 5: reset in the middle of a load, then a clean load
      w0 = obs_we; g0 = obs_go;
      do_start(4);
      send(64'h5A, t); send(64'h5B, t);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_rst_ready", s_ready_o, 0);
      chk("t5_rst_busy", busy_o, 0);
      chk("t5_rst_we", bank_we_o, 0);
      chk("t5_rst_data", wr_data_o, 0);
      idle(6);
      chk("t5_go_count", obs_go - g0, 0);
      chk("t5_writes", obs_we - w0, 2);
      do_start(2);
      send(64'h77, t); send(64'h88, t);
      wait_go();
      chk("t5_go_after", obs_go - g0, 1);
      chk("t5_last_addr", obs_last_addr, 1);
      done_pulse();

      // 6: stale done during LOAD, start during WAIT_DONE
      d0 = obs_done; e0 = obs_err;
      core_done_i = 1'b1;
      do_start(2);
      send(64'h1, t); send(64'h2, t);
      core_done_i = 1'b0;
      wait_go();
      tick();
      do_start(4);
      idle(2);
      chk("t6_done_early", obs_done - d0, 0);
      chk("t6_err", obs_err - e0, 0);
      chk("t6_busy", busy_o, 1);
      done_pulse();
      chk("t6_done", obs_done - d0, 1);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
